// File: rtl/mdu_pkg.sv
// Shared definitions for the idu_mdu multiply/divide unit: op encoding, FSM states, W-result helper.
package mdu_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] MDU_MUL  = 3'd0;
  localparam logic [2:0] MDU_DIV  = 3'd1;
  localparam logic [2:0] MDU_DIVU = 3'd2;
  localparam logic [2:0] MDU_REM  = 3'd3;
  localparam logic [2:0] MDU_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring-division datapath on unsigned magnitudes; one quotient bit per step.
module mdu_divider #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo_nxt,
  output logic [XLEN-1:0] o_rem_nxt
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN+1:0] w_trial;
  logic            w_fits;

  // Trial subtraction of the divisor from the shifted partial remainder; the extra top bit is the borrow.
  assign w_trial   = {1'b0, r_rem, r_quo[XLEN-1]} - {2'b00, r_dvs};
  assign w_fits    = ~w_trial[XLEN+1];
  assign o_quo_nxt = {r_quo[XLEN-2:0], w_fits};
  assign o_rem_nxt = w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};

  // Load operands on start, otherwise advance one step while iterating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem <= {XLEN{1'b0}};
      r_quo <= {XLEN{1'b0}};
      r_dvs <= {XLEN{1'b0}};
    end else if (i_load) begin
      r_rem <= {XLEN{1'b0}};
      // W dividends are pre-aligned to the top so 32 steps consume exactly their bits.
      r_quo <= i_word ? {i_dividend[31:0], {(XLEN-32){1'b0}}} : i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
    end else begin
      r_rem <= r_rem;
      r_quo <= r_quo;
    end
  end

endmodule

// File: rtl/idu_mdu.sv
// Iterative RV64 M-extension multiply/divide unit with valid/ready handshakes.
// Define IDU_MDU_FAST_MUL_EN to make MUL/MULW complete in a single cycle.
module idu_mdu #(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  import mdu_pkg::*;

  mdu_state_e      r_state;
  logic [6:0]      r_cnt;
  logic [6:0]      r_last;
  logic [2:0]      r_op;
  logic            r_word;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_prod;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_signed;
  logic            w_is_div;
  logic            w_reserved;
  logic            w_fast_mul;
  logic            w_div_zero;
  logic            w_fast;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_fast_raw;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_prod_nxt;
  logic [XLEN-1:0] w_iter_raw;
  logic [XLEN-1:0] w_iter_result;

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign w_accept    = i_in_valid & o_in_ready & ~i_flush;

  // Operand preparation and the results that complete without iterating.
  always_comb begin
    w_signed   = (i_op == MDU_DIV) || (i_op == MDU_REM);
    w_is_div   = (i_op == MDU_DIV) || (i_op == MDU_DIVU) || (i_op == MDU_REM) || (i_op == MDU_REMU);
    w_reserved = !(w_is_div || (i_op == MDU_MUL));
`ifdef IDU_MDU_FAST_MUL_EN
    w_fast_mul = (i_op == MDU_MUL);
`else
    w_fast_mul = 1'b0;
`endif
    if (i_word) begin
      w_a = {{(XLEN-32){w_signed & i_src1[31]}}, i_src1[31:0]};
      w_b = {{(XLEN-32){w_signed & i_src2[31]}}, i_src2[31:0]};
    end else begin
      w_a = i_src1;
      w_b = i_src2;
    end
    w_a_neg    = w_signed & w_a[XLEN-1];
    w_b_neg    = w_signed & w_b[XLEN-1];
    w_a_mag    = w_a_neg ? (~w_a + {{(XLEN-1){1'b0}}, 1'b1}) : w_a;
    w_b_mag    = w_b_neg ? (~w_b + {{(XLEN-1){1'b0}}, 1'b1}) : w_b;
    w_div_zero = w_is_div && (w_b == {XLEN{1'b0}});
    w_fast     = w_div_zero | w_reserved | w_fast_mul;
    if (w_reserved) begin
      w_fast_raw = {XLEN{1'b0}};
    end else if (w_div_zero) begin
      w_fast_raw = ((i_op == MDU_DIV) || (i_op == MDU_DIVU)) ? {XLEN{1'b1}} : w_a;
    end else begin
`ifdef IDU_MDU_FAST_MUL_EN
      w_fast_raw = w_a * w_b;
`else
      w_fast_raw = {XLEN{1'b0}};
`endif
    end
    w_fast_result = i_word ? sext_w(w_fast_raw) : w_fast_raw;
  end

  mdu_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_step     (r_state == ST_BUSY),
    .i_word     (i_word),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_quo_nxt  (w_quo_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  // Final-step values with sign fix-up, so the result is ready on the BUSY->DONE edge.
  always_comb begin
    w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    case (r_op)
      MDU_MUL:            w_iter_raw = w_prod_nxt;
      MDU_DIV, MDU_DIVU:  w_iter_raw = r_neg_q ? (~w_quo_nxt + {{(XLEN-1){1'b0}}, 1'b1}) : w_quo_nxt;
      MDU_REM, MDU_REMU:  w_iter_raw = r_neg_r ? (~w_rem_nxt + {{(XLEN-1){1'b0}}, 1'b1}) : w_rem_nxt;
      default:            w_iter_raw = {XLEN{1'b0}};
    endcase
    w_iter_result = r_word ? sext_w(w_iter_raw) : w_iter_raw;
  end

  // Control FSM plus the shift-add multiplier registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 7'd0;
      r_last      <= 7'd0;
      r_op        <= 3'd0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_mcand     <= {XLEN{1'b0}};
      r_mplier    <= {XLEN{1'b0}};
      r_prod      <= {XLEN{1'b0}};
      r_result    <= {XLEN{1'b0}};
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= i_op;
            r_word   <= i_word;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_mcand  <= w_a;
            r_mplier <= w_b;
            r_prod   <= {XLEN{1'b0}};
            r_cnt    <= 7'd0;
            r_last   <= i_word ? 7'd31 : 7'd63;
            if (w_fast) begin
              r_state     <= ST_DONE;
              r_result    <= w_fast_result;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_BUSY;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_cnt    <= r_cnt + 7'd1;
          r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_prod   <= w_prod_nxt;
          if (r_cnt == r_last) begin
            r_state     <= ST_DONE;
            r_result    <= w_iter_result;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/idu_mdu.md
# idu_mdu

Iterative multiply/divide unit for the RV64 core, directly downstream of the decode stage. It consumes the decoder's multiply/divide operations (`mul`, `mulw`, `div`, `divw`, `divu`, `rem`, `remw`, `remu` and their siblings) together with the already-selected operands. It computes the result over multiple cycles and returns it to the execute/writeback path through a valid/ready handshake. A single-cycle ALU handles everything else. This block exists so that the long-latency M-extension operations do not sit on the ALU critical path.

## Interface

Parameters:
- `XLEN`, default 64: datapath width. Only 64 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. This polarity and synchronicity are fixed.
- `flush` in 1: abort any in-flight operation and drop a pending result.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the block accepts. This is high only in IDLE.
- `op` in 3: operation select. 0 = MUL, 1 = DIV, 2 = DIVU, 3 = REM, 4 = REMU, 5–7 reserved.
- `word` in 1: 32-bit (W) variant.
- `src1`, `src2` in XLEN: operands. For W ops, only bits [31:0] are used.
- `out_valid` out 1: the result is valid. It is held until `out_ready`.
- `out_ready` in 1: the consumer takes the result.
- `result` out XLEN: the result.
- `busy` out 1: the state is not IDLE.

## Operation

States and transitions:
- IDLE → BUSY on accept, i.e. `in_valid & in_ready`.
- IDLE → DONE directly on accept in the fast cases: divide-by-zero, a reserved `op`, or fast MUL.
- BUSY → DONE when the iteration counter reaches N.
- DONE → IDLE on `out_ready`.

Operand preparation, at accept:
- W ops take `src[31:0]`. DIV and REM sign-extend it; DIVU, REMU and MUL zero-extend it.
- N = 32 for W ops, 64 otherwise.

MUL:
- Shift-add, one multiplier bit per cycle.
- Result is the low XLEN bits of the product.

DIV/REM:
- Restoring division on magnitudes, one quotient bit per cycle.
- The sign is fixed up in the DONE transition:
  - quotient sign = sign(src1) XOR sign(src2);
  - remainder sign = sign(src1).

Divisor = 0:
- Quotient = all ones; remainder = dividend, after W truncation/extension.
- Completes without iterating.

Signed overflow (most-negative ÷ −1):
- Quotient = most-negative value; remainder = 0.
- This falls out of the magnitude algorithm and needs no special path.

Reserved `op`: result = 0, completes without iterating.

W result: always sign-extended from bit 31, including DIVUW and REMUW.

`result` is registered and stays stable while `out_valid & !out_ready`.

## Timing

Reset values:
- State = IDLE.
- `out_valid` = 0, `result` = 0, `busy` = 0, `in_ready` = 1.

Latency, counting the accept cycle as cycle 0:
- Iterative ops: BUSY in cycles 1..N, `out_valid` first high in cycle N+1. That is cycle 65 for 64-bit ops and cycle 33 for W ops.
- Fast cases: `out_valid` high in cycle 1.

Handshakes:
- No accept is possible in the same cycle as the output handshake. The earliest next accept is the cycle after `out_valid & out_ready`.
- `in_ready` is combinational from the state and does not depend on `in_valid`.

Flush and reset:
- `flush` in any state → IDLE next cycle, with `out_valid` = 0.
- `flush` together with `in_valid` in IDLE: flush wins and nothing is accepted.
- `rst` mid-operation behaves like flush and also clears `result`.

## Configuration

- `IDU_MDU_FAST_MUL_EN` defined: MUL (both 64-bit and W) uses a single-cycle `*`, registered into `result`. It takes the fast path with `out_valid` in cycle 1.
- Macro undefined: MUL is iterative, taking N+1 cycles. DIV/REM are iterative in both builds.

## Structure

Shared package `mdu_pkg` contains:
- the `op` encoding constants (`MDU_MUL` … `MDU_REMU`);
- the state enum (IDLE/BUSY/DONE);
- `XLEN`.

One natural sub-module is `mdu_divider`, the restoring-division datapath (one quotient bit per step).
- It owns the partial-remainder and quotient registers.
- It is started by the top level and returns magnitudes.
- Sign fix-up, operand preparation, the multiplier and the FSM stay in the top level.

## Test plan

- MUL, 64-bit, `src1`=7, `src2`=−3 → `result` 0xFFFF_FFFF_FFFF_FFEB. `out_valid` in cycle 65, or in cycle 1 with `IDU_MDU_FAST_MUL_EN`.
- DIVU `src1`=0x1234, `src2`=0 → `result` 0xFFFF_FFFF_FFFF_FFFF in cycle 1. REMU with the same operands → 0x1234.
- DIV `src1`=0x8000_0000_0000_0000, `src2`=−1 → `result` 0x8000_0000_0000_0000. REM with the same operands → 0.
- DIVW `src1`=0x0000_0000_FFFF_FFF9, `src2`=2 → 0xFFFF_FFFF_FFFF_FFFD in cycle 33. REMW → 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result` stable, `in_ready`=0, `busy`=1. On `out_ready`=1 → IDLE next cycle.
- `flush` in BUSY cycle 10 → IDLE, `out_valid` never asserts. A new op issued immediately afterwards produces a correct result. Repeat with `rst` in place of `flush` → all outputs return to their reset values.
